// File: rtl/uart_cpu_bridge.sv
// CPU-bus slave bridging byte-wide register accesses to a UART core through TX/RX FIFOs.
// Define UART_BRIDGE_TSTAMP_EN to tag each RX byte with the 48-bit arrival timestamp.
module uart_cpu_bridge #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AddrBus,
    input  logic        n_ChipSelect,
    input  logic        n_rd,
    input  logic        n_we,
    input  logic [7:0]  DataBusI,
    output logic [7:0]  DataBusO,
    output logic        p_IrqSig,
    input  logic [3:0]  acqurate_stamp,
    input  logic [11:0] millisecond_stamp,
    input  logic [31:0] second_stamp,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef UART_BRIDGE_TSTAMP_EN
    localparam int unsigned EW = 56;
`else
    localparam int unsigned EW = 8;
`endif

    logic          rd_prev_q, we_prev_q;
    logic [EW-1:0] rx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]    irq_en_q, irq_en_d;
    logic          rx_ovf_q, rx_ovf_d, rx_err_q, rx_err_d, tx_ovf_q, tx_ovf_d;
    logic [7:0]    dout_q, dout_d;
    logic          irq_q, irq_d;

    logic rd_fire, we_fire, ctl_wr;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_flush, rx_pop, rx_push, rx_drop;
    logic tx_flush, tx_pop, tx_req, tx_push, tx_drop;
    logic [EW-1:0] rx_entry, rx_head;
    logic [47:0]   head_stamp;
    logic [7:0]    head_byte, rdata;

    // Accesses fire once on the falling edge of a strobe while selected.
    assign rd_fire = !n_ChipSelect && !n_rd && rd_prev_q;
    assign we_fire = !n_ChipSelect && !n_we && we_prev_q;
    assign ctl_wr  = we_fire && (AddrBus == 4'h3);

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));

    assign rx_flush = ctl_wr && DataBusI[3];
    assign rx_pop   = rd_fire && (AddrBus == 4'h0) && !rx_empty;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign rx_drop  = rx_valid && rx_full && !rx_pop;

    assign tx_flush = ctl_wr && DataBusI[4];
    assign tx_pop   = !tx_empty && tx_ready;
    assign tx_req   = we_fire && (AddrBus == 4'h0);
    assign tx_push  = tx_req && (!tx_full || tx_pop);
    assign tx_drop  = tx_req && tx_full && !tx_pop;

    assign rx_head = rx_mem_q[rx_rptr_q];
`ifdef UART_BRIDGE_TSTAMP_EN
    assign rx_entry   = {rx_data, second_stamp, millisecond_stamp, acqurate_stamp};
    assign head_stamp = rx_empty ? 48'h0 : rx_head[47:0];
`else
    logic unused_stamp;
    assign unused_stamp = ^{acqurate_stamp, millisecond_stamp, second_stamp};
    assign rx_entry     = rx_data;
    assign head_stamp   = 48'h0;
`endif
    assign head_byte = rx_empty ? 8'h00 : rx_head[EW-1 -: 8];

    function automatic logic [7:0] sat8(input logic [CW-1:0] c);
        return (32'(c) > 32'd255) ? 8'hFF : 8'(c);
    endfunction

    always_comb begin
        rdata = 8'h00;
        case (AddrBus)
            4'h0: rdata = head_byte;
            4'h1: rdata = {1'b0, tx_ovf_q, rx_err_q, rx_ovf_q, tx_full, tx_empty, rx_full,
                           !rx_empty};
            4'h2: rdata = {5'b0, irq_en_q};
            4'h4: rdata = head_stamp[23:16];
            4'h5: rdata = head_stamp[31:24];
            4'h6: rdata = head_stamp[39:32];
            4'h7: rdata = head_stamp[47:40];
            4'h8: rdata = head_stamp[11:4];
            4'h9: rdata = {head_stamp[3:0], head_stamp[15:12]};
            4'hA: rdata = sat8(rx_cnt_q);
            4'hB: rdata = sat8(tx_cnt_q);
            default: rdata = 8'h00;
        endcase
    end

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + AW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);
            rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        end
        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + AW'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + AW'(1);
            tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        end

        // New events win over a same-cycle clear so none is lost.
        rx_ovf_d = (rx_ovf_q && !(ctl_wr && DataBusI[0])) || rx_drop;
        rx_err_d = (rx_err_q && !(ctl_wr && DataBusI[1])) || (rx_valid && rx_err);
        tx_ovf_d = (tx_ovf_q && !(ctl_wr && DataBusI[2])) || tx_drop;

        irq_en_d = (we_fire && (AddrBus == 4'h2)) ? DataBusI[2:0] : irq_en_q;
        dout_d   = rd_fire ? rdata : dout_q;
        irq_d    = (irq_en_q[0] && !rx_empty) || (irq_en_q[1] && tx_empty) ||
                   (irq_en_q[2] && (rx_ovf_q || rx_err_q || tx_ovf_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_prev_q <= 1'b1;
            we_prev_q <= 1'b1;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            irq_en_q  <= 3'b000;
            rx_ovf_q  <= 1'b0;
            rx_err_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            dout_q    <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            rd_prev_q <= n_rd;
            we_prev_q <= n_we;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            irq_en_q  <= irq_en_d;
            rx_ovf_q  <= rx_ovf_d;
            rx_err_q  <= rx_err_d;
            tx_ovf_q  <= tx_ovf_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push && !rx_flush) rx_mem_q[rx_wptr_q] <= rx_entry;
        if (tx_push && !tx_flush) tx_mem_q[tx_wptr_q] <= DataBusI;
    end

    assign DataBusO = dout_q;
    assign p_IrqSig = irq_q;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rptr_q];

endmodule
